// File: rtl/dbus_responder.sv
// dbus_responder: slave end of the data bus. Accepts one request at a time,
// holds it for a fixed number of wait cycles, then performs the RAM access
// and answers with a single-cycle addr_ok/data_ok pulse.

package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int DEPTH   = 1024, // 64-bit words, power of two
  parameter int LATENCY = 2     // wait cycles between accept and response, 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_idx;
  logic [7:0]      r_strobe;
  logic [63:0]     r_wdata;
  logic [63:0]     r_rdata;

  // Word-addressed backing store; never touched by reset.
  logic [63:0]     r_mem [0:DEPTH-1];

  // The access happens on the last WAIT cycle. Because this is decoded from
  // the asynchronously reset state, a write caught by reset never lands.
  logic            w_fire;
  logic            w_is_write;
  logic [7:0]      w_byte_en;

  assign w_fire     = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_is_write = |r_strobe;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte_en
      assign w_byte_en[gi] = w_fire & r_strobe[gi];
    end
  endgenerate

  // size, the byte offset and address bits above the RAM index are don't-care.
  logic w_unused;
  assign w_unused = ^{dreq.size, dreq.addr[63:AW+3], dreq.addr[2:0]};

  // Control FSM: latch request at accept, count down, access RAM, respond once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_strobe <= 8'd0;
      r_wdata  <= 64'd0;
      r_rdata  <= 64'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dreq.valid) begin
            r_idx    <= dreq.addr[3 +: AW];
            r_strobe <= dreq.strobe;
            r_wdata  <= dreq.data;
            r_cnt    <= 4'(LATENCY - 1);
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Writes answer with zero data; reads capture the stored word.
            r_rdata <= w_is_write ? 64'd0 : r_mem[r_idx];
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Always spend one IDLE cycle between transactions.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte-strobed RAM write, committed on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (w_byte_en[i]) begin
        r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  // Response decoded from state only; no path from dreq reaches dresp.
  always_comb begin
    dresp = '0;
    if (r_state == ST_RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = r_rdata;
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: stimulus pushes expected responses (data and
// arrival cycle) into a scoreboard queue; a negedge monitor pops and compares
// whenever data_ok is seen. A second LATENCY=1 instance checks short latency.

module tb_dbus_responder;
  import dbus_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic       clk;
  logic       reset;
  logic       rst1;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  dreq1;
  dbus_resp_t dresp1;

  dbus_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp)
  );

  dbus_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .dreq  (dreq1),
    .dresp (dresp1)
  );

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [63:0] model_mem [0:DEPTH-1];
  int          cyc    = 0;
  int          n_resp = 0;
  int          n_vec  = 0;
  int          n_bad  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int widx(input logic [63:0] a);
    return int'((a >> 3) % 64'(DEPTH));
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] st,
                                        input logic [63:0] d);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Monitor: one response per data_ok pulse, checked against the queue head.
  always @(negedge clk) begin
    if (dresp.data_ok) begin
      n_resp++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_data_ok at cycle %0d: got data_ok=1 expected 0", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_data", dresp.data, mon_e.data);
        chk("resp_cycle", 64'(cyc), 64'(mon_e.due));
        chk("resp_addr_ok", 64'(dresp.addr_ok), 64'd1);
      end
    end else begin
      chk("quiet_addr_ok", 64'(dresp.addr_ok), 64'd0);
      chk("quiet_data", dresp.data, 64'd0);
    end
  end

  // Model update at accept time; returns the response the DUT must give.
  function automatic logic [63:0] model_access(input logic [63:0] addr, input logic [7:0] st,
                                               input logic [63:0] d);
    int i;
    i = widx(addr);
    if (st != 8'd0) begin
      model_mem[i] = merge(model_mem[i], st, d);
      return 64'd0;
    end
    return model_mem[i];
  endfunction

  task automatic wait_resp(input int target);
    int budget;
    budget = 0;
    while (n_resp < target && budget < 60) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (n_resp < target) begin
      n_vec++;
      n_bad++;
      $display("FAIL resp_timeout at cycle %0d: got %0d responses expected %0d", cyc, n_resp, target);
      sb_q.delete();
    end
  endtask

  // One transaction, entered and left in an IDLE cycle. hold=0 drops valid and
  // scrambles the request right after accept to show only latched values count.
  task automatic issue(input logic [63:0] addr, input logic [7:0] st,
                       input logic [63:0] d, input bit hold);
    exp_t e;
    int   n0;
    n0 = n_resp;
    dreq.valid  = 1'b1;
    dreq.addr   = addr;
    dreq.size   = 3'd3;
    dreq.strobe = st;
    dreq.data   = d;
    @(posedge clk);
    #1;
    e.data = model_access(addr, st, d);
    e.due  = cyc + LAT;
    sb_q.push_back(e);
    if (!hold) begin
      dreq.valid  = 1'b0;
      dreq.addr   = {$urandom, $urandom};
      dreq.strobe = 8'($urandom);
      dreq.data   = {$urandom, $urandom};
    end
    wait_resp(n0 + 1);
    dreq.valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Single transaction on the LATENCY=1 instance with direct cycle checks.
  task automatic issue1(input logic [63:0] addr, input logic [7:0] st,
                        input logic [63:0] d, input logic [63:0] exp);
    dreq1.valid  = 1'b1;
    dreq1.addr   = addr;
    dreq1.size   = 3'd3;
    dreq1.strobe = st;
    dreq1.data   = d;
    @(posedge clk);
    #1;
    dreq1.valid = 1'b0;
    @(negedge clk);
    chk("lat1_cycle1_data_ok", 64'(dresp1.data_ok), 64'd0);
    @(negedge clk);
    chk("lat1_cycle2_data_ok", 64'(dresp1.data_ok), 64'd1);
    chk("lat1_cycle2_data", dresp1.data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t        e;
    int          a0;
    int          n0;
    logic [63:0] addr;
    logic [7:0]  st;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;
    reset = 1'b1;
    rst1  = 1'b1;
    dreq  = '0;
    dreq1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ok_flags", {62'd0, dresp.addr_ok, dresp.data_ok}, 64'd0);
    chk("reset_data", dresp.data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rst1  = 1'b0;
    @(posedge clk);
    #1;

    // Short-latency instance: data_ok lands in cycle 2.
    issue1(64'h18, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0);
    issue1(64'h18, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF);

    // Known contents everywhere so reads never depend on power-up state.
    for (int i = 0; i < DEPTH; i++) issue(64'(i) << 3, 8'hFF, 64'd0, 1'b0);

    // Full write, read back, partial strobe merge.
    issue(64'h80, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    issue(64'h80, 8'h00, 64'd0, 1'b1);
    issue(64'h80, 8'h0F, 64'h1111_1111_2222_2222, 1'b1);
    issue(64'h80, 8'h00, 64'd0, 1'b1);

    // Address wrap and ignored byte offset.
    issue(64'h2000, 8'h01, 64'h55, 1'b0);
    issue(64'h0003, 8'h00, 64'd0, 1'b0);

    // Valid held: responses in cycles LAT+1 and 2*LAT+3 after first sample.
    n0 = n_resp;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h80;
    dreq.strobe = 8'h00;
    dreq.data   = 64'd0;
    @(posedge clk);
    #1;
    a0     = cyc;
    e.data = model_access(64'h80, 8'h00, 64'd0);
    e.due  = a0 + LAT;
    sb_q.push_back(e);
    e.due  = a0 + 2 * LAT + 2;
    sb_q.push_back(e);
    while (cyc < a0 + LAT + 2) begin
      @(posedge clk);
      #1;
    end
    dreq.valid = 1'b0;
    wait_resp(n0 + 2);
    @(posedge clk);
    #1;

    // Reset during WAIT of a write: write discarded, no response.
    issue(64'h40, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    n0 = n_resp;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h40;
    dreq.strobe = 8'hFF;
    dreq.data   = '1;
    @(posedge clk);
    #1;
    dreq.valid = 1'b0;
    reset      = 1'b1;
    #1;
    chk("rst_wait_data_ok", 64'(dresp.data_ok), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_wait_no_resp", 64'(n_resp), 64'(n0));
    issue(64'h40, 8'h00, 64'd0, 1'b0);

    // Reset during RESP clears dresp without waiting for a clock edge.
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h40;
    dreq.strobe = 8'h00;
    @(posedge clk);
    #1;
    a0     = cyc;
    e.data = model_access(64'h40, 8'h00, 64'd0);
    e.due  = a0 + LAT;
    sb_q.push_back(e);
    dreq.valid = 1'b0;
    while (cyc < a0 + LAT) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_resp_data_ok", 64'(dresp.data_ok), 64'd0);
    chk("rst_resp_data", dresp.data, 64'd0);
    chk("rst_resp_consumed", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomised traffic over a small word set, with wrapped addresses.
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      addr       = {$urandom, $urandom};
      addr[12:3] = 10'($urandom_range(0, 15));
      st         = ($urandom_range(0, 9) < 3) ? 8'h00 : 8'($urandom);
      issue(addr, st, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    // Nothing further may arrive once the bus is quiet.
    n0 = n_resp;
    repeat (12) @(posedge clk);
    #1;
    chk("quiet_tail_resp_count", 64'(n_resp), 64'(n0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
